// File: rtl/snk_pkg.sv
// Shared constants and types for the snake motion engine.
package snk_pkg;

  localparam int unsigned BITS = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned START_X = 3;
  localparam int unsigned START_Y = 3;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_e dir_reverse(dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snk_btn_edge.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse.
module snk_btn_edge (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic pulse
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/snk_mover.sv
// Snake motion engine: start/pause FSM, tick divider, direction latch, head and body history.
module snk_mover
  import snk_pkg::*;
#(
  parameter int unsigned BITS     = snk_pkg::BITS,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned LEN      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  btn_up,
  input  logic                  btn_right,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_start,
  output logic [2*BITS:0]       snake,
  output logic [LEN*2*BITS-1:0] body,
  output logic                  step_pulse,
  output logic [1:0]            state_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [2*BITS-1:0] START_CELL = {BITS'(START_X), BITS'(START_Y)};

  logic up_edge, right_edge, down_edge, left_edge, start_edge;

  snk_btn_edge u_up    (.CLK(CLK), .RST(RST), .btn(btn_up),    .pulse(up_edge));
  snk_btn_edge u_right (.CLK(CLK), .RST(RST), .btn(btn_right), .pulse(right_edge));
  snk_btn_edge u_down  (.CLK(CLK), .RST(RST), .btn(btn_down),  .pulse(down_edge));
  snk_btn_edge u_left  (.CLK(CLK), .RST(RST), .btn(btn_left),  .pulse(left_edge));
  snk_btn_edge u_start (.CLK(CLK), .RST(RST), .btn(btn_start), .pulse(start_edge));

  state_e state_q, state_d;
  logic   running, active, step;
  logic [CW-1:0] cnt_q, cnt_d;
  dir_e   dir_cur_q, dir_cur_d, dir_next_q, dir_next_d, req_dir;
  logic   req_vld;
  logic [BITS-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [LEN-1:0][2*BITS-1:0] body_q, body_d;
  logic   step_pulse_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Encoding 3 is unreachable and behaves as IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (start_edge) state_d = ST_PAUSE;
      ST_PAUSE: if (start_edge) state_d = ST_RUN;
      default:  if (start_edge) state_d = ST_RUN;
    endcase
  end

  always_comb begin
    running = 1'b0;
    active  = 1'b0;
    state_o = ST_IDLE;
    case (state_q)
      ST_RUN: begin
        running = 1'b1;
        active  = 1'b1;
        state_o = ST_RUN;
      end
      ST_PAUSE: begin
        active  = 1'b1;
        state_o = ST_PAUSE;
      end
      default: ;
    endcase
  end

  assign step = running && (cnt_q == CNT_LAST);

  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_UP;
    if (up_edge)         req_dir = DIR_UP;
    else if (right_edge) req_dir = DIR_RIGHT;
    else if (down_edge)  req_dir = DIR_DOWN;
    else if (left_edge)  req_dir = DIR_LEFT;
    else                 req_vld = 1'b0;
  end

  always_comb begin
    cnt_d      = cnt_q;
    dir_cur_d  = dir_cur_q;
    dir_next_d = dir_next_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    body_d     = body_q;
    if (!active) begin
      cnt_d      = '0;
      dir_cur_d  = DIR_RIGHT;
      dir_next_d = DIR_RIGHT;
    end else begin
      if (running) cnt_d = step ? '0 : cnt_q + 1'b1;
      // The reverse check uses the direction in force, not the pending one.
      if (req_vld && (req_dir != dir_reverse(dir_cur_q))) dir_next_d = req_dir;
      if (step) begin
        dir_cur_d = dir_next_q;
        case (dir_next_q)
          DIR_UP:    head_y_d = head_y_q - 1'b1;
          DIR_RIGHT: head_x_d = head_x_q + 1'b1;
          DIR_DOWN:  head_y_d = head_y_q + 1'b1;
          default:   head_x_d = head_x_q - 1'b1;
        endcase
        body_d[0] = {head_x_q, head_y_q};
        for (int k = 1; k < LEN; k++) body_d[k] = body_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q        <= '0;
      dir_cur_q    <= DIR_RIGHT;
      dir_next_q   <= DIR_RIGHT;
      head_x_q     <= BITS'(START_X);
      head_y_q     <= BITS'(START_Y);
      body_q       <= {LEN{START_CELL}};
      step_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_cur_q    <= dir_cur_d;
      dir_next_q   <= dir_next_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      body_q       <= body_d;
      step_pulse_q <= step;
    end
  end

  assign snake      = {active, head_x_q, head_y_q};
  assign body       = body_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_snk_mover.sv
// Bench for snk_mover: directed vector table plus random buttons against a game-level model.
module tb_snk_mover;

  localparam int TD = 4;
  localparam int L  = 4;
  localparam int B  = 3;
  localparam int W  = 1 << B;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_start = 1'b0;
  logic [2*B:0]     snake;
  logic [L*2*B-1:0] body;
  logic             step_pulse;
  logic [1:0]       state_o;

  snk_mover #(.BITS(B), .TICK_DIV(TD), .LEN(L)) dut (
    .CLK(CLK), .RST(RST),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .btn_start(btn_start),
    .snake(snake), .body(body), .step_pulse(step_pulse), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bit 0 up, 1 right, 2 down, 3 left, 4 start
  task automatic set_btns(input logic [4:0] m);
    btn_up    = m[0];
    btn_right = m[1];
    btn_down  = m[2];
    btn_left  = m[3];
    btn_start = m[4];
  endtask

  // ---------------- game-level reference model ----------------
  int m_mode;   // 0 idle, 1 run, 2 pause
  int m_cnt, m_dcur, m_dnext, m_hx, m_hy, m_step;
  int m_bx[$];
  int m_by[$];
  logic [4:0] h1, h2, h3;   // button samples from 1, 2 and 3 edges ago

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_dcur = 1; m_dnext = 1; m_hx = 3; m_hy = 3; m_step = 0;
    m_bx = {}; m_by = {};
    for (int k = 0; k < L; k++) begin
      m_bx.push_back(3);
      m_by.push_back(3);
    end
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_step();
    logic [4:0] e;
    int req, odc, odn;
    bit st;
    e  = h2 & ~h3;
    h3 = h2;
    h2 = h1;
    h1 = {btn_start, btn_left, btn_down, btn_right, btn_up};
    req = -1;
    for (int d = 0; d < 4; d++) if (e[d] && req < 0) req = d;
    st  = (m_mode == 1) && (m_cnt == TD - 1);
    odc = m_dcur;
    odn = m_dnext;
    if (m_mode == 0) begin
      m_cnt = 0; m_dcur = 1; m_dnext = 1;
      if (e[4]) m_mode = 1;
    end else begin
      if (st) begin
        m_dcur = odn;
        m_bx.push_front(m_hx);
        m_by.push_front(m_hy);
        void'(m_bx.pop_back());
        void'(m_by.pop_back());
        case (odn)
          0:       m_hy = (m_hy + W - 1) % W;
          1:       m_hx = (m_hx + 1) % W;
          2:       m_hy = (m_hy + 1) % W;
          default: m_hx = (m_hx + W - 1) % W;
        endcase
        m_cnt = 0;
      end else if (m_mode == 1) begin
        m_cnt++;
      end
      if (req >= 0 && req != (odc + 2) % 4) m_dnext = req;
      if (e[4]) m_mode = (m_mode == 1) ? 2 : 1;
    end
    m_step = st;
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) model_reset();
    else      model_step();
  end

  function automatic logic [L*2*B-1:0] exp_body();
    logic [L*2*B-1:0] r;
    int x, y;
    r = '0;
    for (int k = 0; k < L; k++) begin
      x = m_bx[k];
      y = m_by[k];
      r[k*2*B +: 2*B] = {x[B-1:0], y[B-1:0]};
    end
    return r;
  endfunction

  bit chk_en = 1'b0;
  always @(negedge CLK) begin
    if (chk_en && RST) begin
      logic [2*B:0] es;
      es = {(m_mode != 0), m_hx[B-1:0], m_hy[B-1:0]};
      chk("model_snake", snake, es);
      chk("model_body", body, exp_body());
      chk("model_step", step_pulse, m_step);
      chk("model_state", state_o, m_mode);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int         pre;
    logic [4:0] press;
    int         wait_n;
    logic [6:0] exp_snake;
    logic [1:0] exp_state;
    logic       exp_step;
  } vec_t;

  vec_t vt[$];

  initial begin
    // pre-cycles, press mask, cycles after press, {valid,x,y}, state, step_pulse
    vt.push_back('{0, 5'b00000, 50, 7'b0_011_011, 2'd0, 1'b0}); // idle, nothing moves
    vt.push_back('{0, 5'b10000,  2, 7'b1_011_011, 2'd1, 1'b0}); // start -> run
    vt.push_back('{0, 5'b00000,  4, 7'b1_100_011, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_101_011, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_110_011, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_111_011, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_000_011, 2'd1, 1'b1}); // x wraps 7 -> 0
    vt.push_back('{0, 5'b01000,  3, 7'b1_001_011, 2'd1, 1'b1}); // LEFT is reverse: dropped
    vt.push_back('{0, 5'b00001,  3, 7'b1_001_010, 2'd1, 1'b1}); // UP
    vt.push_back('{0, 5'b00000,  4, 7'b1_001_001, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_001_000, 2'd1, 1'b1});
    vt.push_back('{0, 5'b00000,  4, 7'b1_001_111, 2'd1, 1'b1}); // y wraps 0 -> 7
    vt.push_back('{0, 5'b01001,  3, 7'b1_001_110, 2'd1, 1'b1}); // UP beats LEFT
    vt.push_back('{0, 5'b00100,  3, 7'b1_001_101, 2'd1, 1'b1}); // DOWN reverse: dropped
    vt.push_back('{0, 5'b01000,  3, 7'b1_000_101, 2'd1, 1'b1}); // LEFT
    vt.push_back('{1, 5'b00100,  2, 7'b1_111_101, 2'd1, 1'b1}); // DOWN lands on step edge
    vt.push_back('{0, 5'b00000,  4, 7'b1_111_110, 2'd1, 1'b1}); // ...applied one step later
    vt.push_back('{0, 5'b10000,  3, 7'b1_111_110, 2'd2, 1'b0}); // pause with count 3
    vt.push_back('{0, 5'b00000, 20, 7'b1_111_110, 2'd2, 1'b0}); // frozen
    vt.push_back('{0, 5'b10000,  2, 7'b1_111_110, 2'd1, 1'b0}); // resume
    vt.push_back('{0, 5'b00000,  1, 7'b1_111_111, 2'd1, 1'b1}); // step one cycle later
    vt.push_back('{1, 5'b10000,  2, 7'b1_111_000, 2'd2, 1'b1}); // step and pause same edge
    vt.push_back('{0, 5'b00000, 10, 7'b1_111_000, 2'd2, 1'b0});
    vt.push_back('{0, 5'b10000,  2, 7'b1_111_000, 2'd1, 1'b0});
    vt.push_back('{0, 5'b00000,  4, 7'b1_111_001, 2'd1, 1'b1}); // counter restarted at 0
  end

  // ---------------- main sequence ----------------
  initial begin
    set_btns(5'b00000);
    repeat (3) @(negedge CLK);
    chk("reset_snake", snake, 7'b0_011_011);
    chk("reset_body", body, {L{6'b011_011}});
    chk("reset_step", step_pulse, 1'b0);
    chk("reset_state", state_o, 2'd0);
    RST    = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      repeat (vt[i].pre) @(negedge CLK);
      if (vt[i].press != 5'b00000) begin
        set_btns(vt[i].press);
        @(negedge CLK);
        set_btns(5'b00000);
      end
      repeat (vt[i].wait_n) @(negedge CLK);
      chk($sformatf("vec%0d_snake", i), snake, vt[i].exp_snake);
      chk($sformatf("vec%0d_state", i), state_o, vt[i].exp_state);
      chk($sformatf("vec%0d_step", i), step_pulse, vt[i].exp_step);
    end

    // Random button activity, checked every cycle by the model.
    for (int c = 0; c < 2000; c++) begin
      logic [4:0] m;
      m[0] = ($urandom_range(0, 7) == 0);
      m[1] = ($urandom_range(0, 7) == 0);
      m[2] = ($urandom_range(0, 7) == 0);
      m[3] = ($urandom_range(0, 7) == 0);
      m[4] = ($urandom_range(0, 59) == 0);
      set_btns(m);
      @(negedge CLK);
    end
    set_btns(5'b00000);
    repeat (4) @(negedge CLK);
    if (m_mode != 1) begin
      set_btns(5'b10000);
      @(negedge CLK);
      set_btns(5'b00000);
      repeat (4) @(negedge CLK);
    end
    chk("pre_reset_running", state_o, 2'd1);
    repeat (6) @(negedge CLK);

    // Asynchronous reset mid-run, checked before any clock edge.
    #2 RST = 1'b0;
    #1;
    chk("async_snake", snake, 7'b0_011_011);
    chk("async_body", body, {L{6'b011_011}});
    chk("async_step", step_pulse, 1'b0);
    chk("async_state", state_o, 2'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_reset_state", state_o, 2'd0);
    chk("post_reset_snake", snake, 7'b0_011_011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snk_mover.md
# snk_mover

Snake motion engine that sits directly upstream of the LED printer stage. It turns debounced push-button inputs into a direction and advances the snake head one cell per game tick on an 8×8 wrap-around field. It also keeps a short shift-register history of previous head positions as the body. The head is emitted in the 7-bit `snake` word that the printer consumes: bit 6 valid, bits 5:3 x, bits 2:0 y.

## Interface
Parameters:
- `BITS`, 3, coordinate width per axis (field is 2^BITS square)
- `TICK_DIV`, 25_000_000, clock cycles per movement step (≥2)
- `LEN`, 4, body history depth in cells (≥1)

Ports:
- `CLK` in 1: single system clock
- `RST` in 1: reset, asynchronous, active-low
- `btn_up`, `btn_right`, `btn_down`, `btn_left` in 1 each: direction buttons, asynchronous, level-high
- `btn_start` in 1: start/pause button, asynchronous, level-high
- `snake` out 2*BITS+1: {valid, x[BITS-1:0], y[BITS-1:0]}
- `body` out LEN*2*BITS: entry k at [k*2*BITS +: 2*BITS] = {x,y}, k=0 newest
- `step_pulse` out 1: high for exactly one cycle when head moves
- `state_o` out 2: FSM state, for debug/LED

## Operation
- All button inputs pass through a 2-flop synchronizer and then a rising-edge detector. Only edges act.
- Direction encoding: UP=0 (y−1), RIGHT=1 (x+1), DOWN=2 (y+1), LEFT=3 (x−1). Row 0 is the top.
- Pending direction register `dir_next`:
  - Latched on a button edge unless the request is the exact reverse of `dir_cur`. Reverse requests are dropped silently.
  - Simultaneous edges: priority UP > RIGHT > DOWN > LEFT.
  - Last accepted edge before a step wins.
- FSM states: IDLE(0), RUN(1), PAUSE(2). State 3 is unreachable and decodes to IDLE.
  - IDLE: `btn_start` edge → RUN. Tick counter cleared. `dir_cur=dir_next=RIGHT`.
  - RUN: `btn_start` edge → PAUSE.
  - PAUSE: `btn_start` edge → RUN. Tick counter resumes from its held value.
  - No transition from RUN/PAUSE back to IDLE except reset.
- Tick counter: runs 0..TICK_DIV−1 in RUN only. It holds in PAUSE and is 0 in IDLE.
- Step occurs when the counter reaches its terminal value in RUN. On a step:
  - `dir_cur ← dir_next`.
  - The head moves one cell in the new `dir_cur`. Arithmetic is modulo 2^BITS (natural BITS-bit wrap: x=7 RIGHT → 0, y=0 UP → 7).
  - `body[0] ← old head`, and `body[k] ← body[k−1]`.
  - `step_pulse=1`.
- Direction edges are accepted in RUN and PAUSE, and ignored in IDLE.
- `snake[2*BITS]` (valid) is 1 in RUN and PAUSE, 0 in IDLE.

## Timing
- Reset values:
  - `snake = 7'b0011011` (valid=0, x=3, y=3).
  - Every `body` entry = {3,3}.
  - `step_pulse=0`, `state_o=IDLE`.
  - Counter 0, `dir_cur=dir_next=RIGHT`.
- Reset mid-operation returns all of the above immediately and asynchronously. Synchronizers also clear.
- Button-to-action latency: a level rising before CLK edge n is edge-detected and acted on at edge n+2. The direction is latched then and applied at the next step.
- From the IDLE→RUN edge, the first step occurs TICK_DIV cycles later. Later steps are every TICK_DIV RUN cycles.
- A step and a `btn_start` edge in the same cycle: the step completes, then the state moves to PAUSE.
- A direction edge in the same cycle as a step is not used by that step; it applies at the following step.
- `snake`, `body` and `step_pulse` are all registered and update on the same edge.

## Structure
- Shared package `snk_pkg`:
  - `BITS` constant.
  - Direction enum/localparams `DIR_UP/RIGHT/DOWN/LEFT`.
  - State localparams `ST_IDLE/RUN/PAUSE`.
  - Start position constant (3,3).
- Sub-module `snk_btn_edge`: a 2-flop synchronizer plus rising-edge pulse, instantiated five times.
- The top level holds the FSM, tick counter, direction logic and body shift register.

## Test plan
All scenarios use TICK_DIV=4 and LEN=4.
1. Reset deasserted, no buttons → `snake=0011011`, `state_o=0`, `step_pulse` never rises over 50 cycles.
2. Start pulse → valid=1 two cycles later, then RIGHT steps every 4 cycles: x=4,5,6,7,0 (wrap), with y=3 throughout. `body[0]` always equals the previous head.
3. In RUN heading RIGHT, press LEFT → dropped. Then press UP → next step gives y=2, and UP from y=0 wraps to y=7.
4. UP and LEFT edges in the same cycle → UP wins. A DOWN press between steps after UP is dropped as a reverse.
5. Start (RUN) then second start (PAUSE) → head and counter freeze for 20 cycles. Third start → first step 4 minus the elapsed count later.
6. Assert RST mid-RUN with head at (6,1) → outputs return to reset values without waiting for a CLK edge.
